// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the MIPS two-master bus arbiter.
// Pure declarations, no logic and therefore no latency.
// No flow control here; waitrequest handling lives in the arbiter top.
package mips_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;

  typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} arb_state_t;
  typedef enum logic {M0, M1} master_id_t;

  // Map a master id onto the FSM state that serves it.
  function automatic arb_state_t busy_state(input master_id_t id);
    return (id == M1) ? BUSY_M1 : BUSY_M0;
  endfunction

endpackage

// File: rtl/mips_bus_arb_pick.sv
// Chooses which requesting master gets the next grant.
// Purely combinational, zero latency.
// No backpressure; optional macro MIPS_ARB_ROUND_ROBIN_EN selects alternating priority.
module mips_bus_arb_pick
  import mips_bus_pkg::*;
(
  input  logic [1:0]  req,
  input  master_id_t  last_grant,
  output logic        grant_valid,
  output master_id_t  grant_id
);

`ifdef MIPS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
  // Fixed priority ignores the history; keep the port for a uniform interface.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Single requester wins outright; on a tie, the data master wins unless
  // round-robin is enabled, in which case the master not served last wins.
  always_comb begin
    grant_valid = |req;
    grant_id    = M0;
    if (req == 2'b11) begin
      if (RR) grant_id = (last_grant == M0) ? M1 : M0;
      else    grant_id = M1;
    end else if (req[1]) begin
      grant_id = M1;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style slave bus between instruction (M0) and data (M1) masters.
// Grant registered one cycle after request; transfer takes >= 2 cycles, no back-to-back grants.
// Granted master sees slave waitrequest; the other master is always stalled (waitrequest=1).
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m_readdata,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic                busy
);

  arb_state_t          state_q, state_d;
  master_id_t          last_grant_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [1:0]          req;
  logic                grant_valid;
  master_id_t          grant_id;

  assign req        = {m1_read | m1_write, m0_read | m0_write};
  assign m_readdata = readdata;
  assign busy       = busy_q;

  mips_bus_arb_pick u_pick (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next state: grant from IDLE; leave BUSY on completion or a dropped request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = busy_state(grant_id);
      BUSY_M0: if (!waitrequest || !req[0]) state_d = IDLE;
      BUSY_M1: if (!waitrequest || !req[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave command mux; in IDLE the fields hold the last driven values.
  always_comb begin
    address        = addr_q;
    writedata      = wdata_q;
    byteenable     = be_q;
    read           = 1'b0;
    write          = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      BUSY_M0: begin
        address        = m0_address;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        write          = m0_write;
        read           = m0_read & ~m0_write;
        m0_waitrequest = waitrequest;
      end
      BUSY_M1: begin
        address        = m1_address;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        write          = m1_write;
        read           = m1_read & ~m1_write;
        m1_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

  // State, grant history, busy flag and held slave fields.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      if (state_q == IDLE && grant_valid) last_grant_q <= grant_id;
      addr_q  <= address;
      wdata_q <= writedata;
      be_q    <= byteenable;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: expected transfers are queued at
// stimulus time and checked when the slave completes a transfer.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            m0_read = 0, m0_write = 0;
  logic [31:0]     m0_address = 0, m0_writedata = 0;
  logic [BE_W-1:0] m0_byteenable = 0;
  logic            m0_waitrequest;
  logic            m1_read = 0, m1_write = 0;
  logic [31:0]     m1_address = 0, m1_writedata = 0;
  logic [BE_W-1:0] m1_byteenable = 0;
  logic            m1_waitrequest;
  logic [31:0]     m_readdata;
  logic [31:0]     address;
  logic            read, write;
  logic [31:0]     writedata;
  logic [BE_W-1:0] byteenable;
  logic            waitrequest = 0;
  logic [31:0]     readdata = 0;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] RD = 32'h24020005;
  localparam logic [31:0] A0 = 32'hBFC00000;
  localparam logic [31:0] A1 = 32'hBFC00010;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest),
    .m_readdata(m_readdata), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion monitor: a transfer completes when a strobe is up and the slave is not stalling.
  int   mon_id;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset && (read || write) && !waitrequest) begin
      if (!m0_waitrequest)      mon_id = 0;
      else if (!m1_waitrequest) mon_id = 1;
      else                      mon_id = 2;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("cmp_id", mon_id, {63'd0, mon_e.id});
        chk("cmp_wr", {63'd0, write}, {63'd0, mon_e.wr});
        chk("cmp_addr", {32'd0, address}, {32'd0, mon_e.addr});
        if (mon_e.wr) chk("cmp_wdata", {32'd0, writedata}, {32'd0, mon_e.data});
        else          chk("cmp_rdata", {32'd0, m_readdata}, {32'd0, mon_e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges.
    reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_read", read, 0);
    chk("rst_write", write, 0);
    chk("rst_m0_wr", m0_waitrequest, 1);
    chk("rst_m1_wr", m1_waitrequest, 1);
    chk("rst_busy", busy, 0);
    chk("rst_addr", address, 0);
    tick();
    reset = 1'b1;

    // Single zero-wait read from M0.
    tick();
    m0_read = 1; m0_address = A0; waitrequest = 0; readdata = RD;
    sb.push_back('{1'b0, 1'b0, A0, RD});
    @(negedge clk);
    chk("rd_t_m0_wr", m0_waitrequest, 1);
    chk("rd_t_read", read, 0);
    tick();
    @(negedge clk);
    chk("rd_t1_read", read, 1);
    chk("rd_t1_addr", address, A0);
    chk("rd_t1_m0_wr", m0_waitrequest, 0);
    chk("rd_t1_rdata", m_readdata, RD);
    chk("rd_t1_busy", busy, 1);
    tick();
    m0_read = 0;
    @(negedge clk);
    chk("rd_t2_busy", busy, 0);
    chk("idle_addr_hold", address, A0);

    // M1 write with three slave wait cycles.
    tick();
    m1_write = 1; m1_address = A1; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'hF;
    waitrequest = 1;
    sb.push_back('{1'b1, 1'b1, A1, 32'hDEADBEEF});
    @(negedge clk);
    chk("ws_t_m1_wr", m1_waitrequest, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      waitrequest = (k < 3);
      @(negedge clk);
      chk("ws_write", write, 1);
      chk("ws_m1_wr", m1_waitrequest, (k < 3) ? 1 : 0);
      chk("ws_m0_wr", m0_waitrequest, 1);
      chk("ws_be", byteenable, 4'hF);
    end
    tick();
    m1_write = 0; waitrequest = 0;
    @(negedge clk);
    chk("ws_done_write", write, 0);

    // M1 asserts read and write together: write only.
    tick();
    m1_read = 1; m1_write = 1; m1_address = 32'h100; m1_writedata = 32'h12345678;
    m1_byteenable = 4'h3;
    sb.push_back('{1'b1, 1'b1, 32'h100, 32'h12345678});
    tick();
    @(negedge clk);
    chk("rw_read", read, 0);
    chk("rw_write", write, 1);
    tick();
    m1_read = 0; m1_write = 0;

    // Contention: both masters request continuously out of reset.
    tick();
    reset = 0;
    m0_read = 1; m0_address = A0; m1_read = 1; m1_address = A1;
    waitrequest = 0; readdata = RD;
`ifdef MIPS_ARB_ROUND_ROBIN_EN
    sb.push_back('{1'b0, 1'b0, A0, RD});
    sb.push_back('{1'b1, 1'b0, A1, RD});
    sb.push_back('{1'b0, 1'b0, A0, RD});
    sb.push_back('{1'b1, 1'b0, A1, RD});
`else
    for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 1'b0, A1, RD});
`endif
    tick();
    @(negedge clk);
    chk("ct_rst_busy", busy, 0);
    tick();
    reset = 1;
    repeat (7) tick();
    @(negedge clk);
    tick();
    m0_read = 0; m1_read = 0;
    @(negedge clk);
    chk("ct_sb_drained", sb.size(), 0);

    // Reset asserted while M1 is stalled mid-transfer.
    tick();
    m1_write = 1; m1_address = 32'h200; waitrequest = 1;
    tick();
    @(negedge clk);
    chk("ra_write_before", write, 1);
    chk("ra_busy_before", busy, 1);
    reset = 0;
    tick();
    reset = 1; m1_write = 0;
    @(negedge clk);
    chk("ra_write", write, 0);
    chk("ra_busy", busy, 0);
    chk("ra_m1_wr", m1_waitrequest, 1);
    waitrequest = 0;

    tick(); tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter that shares the single Avalon-style memory bus of `mips_cpu_bus` between an instruction-fetch requester (M0) and a data-access requester (M1). Each transfer runs under a registered grant that is held until the slave drops `waitrequest`. Masters see a normal bus with `waitrequest` back-pressure, and the slave side connects unchanged to the existing RAM/bus model.

## Interface
- `ADDR_W`, default 32: address width, all ports.
- `DATA_W`, default 32: data width; byteenable width is `DATA_W/8`.

- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `m0_read`, `m0_write` in 1 each: M0 (instruction) command strobes.
- `m0_address` in ADDR_W, `m0_writedata` in DATA_W, `m0_byteenable` in DATA_W/8: M0 command fields.
- `m0_waitrequest` out 1: M0 stall.
- `m1_read`, `m1_write`, `m1_address`, `m1_writedata`, `m1_byteenable`, `m1_waitrequest`: the same set for M1 (data).
- `m_readdata` out DATA_W: slave `readdata`, broadcast unmodified to both masters.
- `address` out ADDR_W, `read` out 1, `write` out 1, `writedata` out DATA_W, `byteenable` out DATA_W/8: slave command.
- `waitrequest` in 1, `readdata` in DATA_W: slave response.
- `busy` out 1: high while a grant is held.

## Operation
- FSM states:
  - `IDLE`: no slave command.
  - `BUSY_M0`: slave bus driven from M0.
  - `BUSY_M1`: slave bus driven from M1.
- A master is *requesting* when its `read | write` is high.
- `IDLE` transitions:
  - No request: stay in `IDLE`.
  - One requester: go to `BUSY_<that master>`.
  - Both requesting: winner is chosen by the arbitration policy (see Configuration).
- `BUSY_x` behaviour:
  - Slave `address`, `writedata` and `byteenable` = master x fields.
  - Slave `write` = `mx_write`; slave `read` = `mx_read & ~mx_write`. A master asserting both strobes performs a write only.
  - `mx_waitrequest` = slave `waitrequest`; the other master's waitrequest = 1.
- Completion: in `BUSY_x`, when slave `waitrequest` = 0, the transfer completes that cycle and the FSM returns to `IDLE`. There are no back-to-back grants.
- Master drops its request in `BUSY_x` before completion (protocol violation): the FSM returns to `IDLE` on the next edge, and the slave strobes follow the master (0).
- In `IDLE`, both master waitrequests = 1, slave `read`/`write` = 0, and the slave fields hold their last value.
- `last_grant` register: updated to x on every entry into `BUSY_x`.
- Reset values: state `IDLE`, `last_grant` = M1, `read`/`write` 0, `address`/`writedata`/`byteenable` 0, `m0_waitrequest`/`m1_waitrequest` 1, `busy` 0.
- Reset asserted mid-transfer: on that edge the FSM goes to `IDLE`, and the slave strobes are 0 from the following cycle. The aborted transfer is not retried.

## Timing
- A request first seen in `IDLE` at cycle t gets its grant registered at the end of t. The slave command is driven in t+1.
- The requesting master sees `waitrequest` = 1 in cycle t (and in every cycle while not granted).
- Slave with zero wait states: completion in t+1; the master sees `waitrequest` = 0 in t+1. Minimum 2 cycles per transfer; the FSM is back in `IDLE` at t+2.
- Each slave wait cycle adds one cycle; there is no timeout.
- `m_readdata` is combinational from `readdata`. It is valid to master x in the completing cycle of a read.
- `busy` = (state != `IDLE`), registered.

## Configuration
- `MIPS_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request in `IDLE`, the grant goes to the master ≠ `last_grant`.
- Macro undefined: fixed priority; M1 (data) always wins a simultaneous request, and `last_grant` is still maintained.

## Structure
- Package `mips_bus_pkg`:
  - `typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} arb_state_t`.
  - `typedef enum logic {M0, M1} master_id_t`.
  - Localparam `BE_W = DATA_W/8` default.
- One sub-module, `mips_bus_arb_pick`:
  - Combinational; inputs are `req[1:0]` and `last_grant`; outputs are `grant_valid` and `grant_id`.
  - The `MIPS_ARB_ROUND_ROBIN_EN` policy is confined here.
- Top level: the FSM plus output muxing.

## Test plan
- Reset: hold `reset`=0 for 2 edges → `read`=`write`=0, both master waitrequests 1, `busy`=0.
- Single read:
  - Stimulus: M0 read at `0xBFC00000`, slave waitrequest 0, readdata `0x24020005`.
  - Required response: cycle t `m0_waitrequest`=1; t+1 `read`=1, `address`=`0xBFC00000`, `m0_waitrequest`=0, `m_readdata`=`0x24020005`; t+2 `busy`=0.
- Wait states: M1 write to `0xBFC00010`, data `0xDEADBEEF`, `byteenable`=`4'hF`, slave waitrequest held 3 cycles → `write`=1 for 4 cycles, `m1_waitrequest` low only in the 4th, `m0_waitrequest`=1 throughout.
- Contention: M0 and M1 request continuously from reset → with the macro, grants alternate M0, M1, M0, M1; without it, M1 wins every time and M0 never completes while M1 requests.
- Read+write strobe: M1 drives read=1 and write=1 → slave `read`=0, `write`=1.
- Reset mid-transfer: `reset`=0 during `BUSY_M1` with slave waitrequest=1 → next cycle `write`=0, `busy`=0, `m1_waitrequest`=1.
